// File: rtl/tetris_pkg.sv
// Shared playfield constants, cell type and scan FSM encoding.
// Used by the row scanner, row-read engine and colour stages.
package tetris_pkg;
  localparam int NUM_ROWS  = 20;
  localparam int NUM_COLS  = 10;
  localparam int CELL_W    = 16;
  localparam int TIMEOUT   = 1023;
  localparam int ROW_IDX_W = $clog2(NUM_ROWS);

  localparam logic [CELL_W-1:0] BKGD_CLR = 16'h0F05;
  localparam logic [CELL_W-1:0] BLCK_CLR = 16'h005F;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    REQ  = 3'd2,
    CHK  = 3'd3,
    FIN  = 3'd4
  } scan_state_t;
endpackage

// File: rtl/row_full_check.sv
// Combinational full-row test: high when no cell holds the background colour.
// Zero latency, no flow control.
module row_full_check
  import tetris_pkg::*;
(
  input  cell_t [NUM_COLS-1:0] cells_i,
  output logic                 full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (cells_i[c] == BKGD_CLR) full_o = 1'b0;
    end
  end

endmodule

// File: rtl/row_scan_ctrl.sv
// Bottom-up line-clear scanner: one row_ld/row_ready handshake per row, >=2 cycles per row.
// Waits indefinitely on row_ready unless SCAN_TIMEOUT_EN adds the watchdog abort.
module row_scan_ctrl
  import tetris_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 row_ready,
  input  cell_t [NUM_COLS-1:0] read_reg,
  output logic                 row_ld,
  output logic [7:0]           row,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_ROWS-1:0]  full_mask,
  output logic [4:0]           full_count,
  output logic [15:0]          lines_total,
  output logic                 scan_err
);

  scan_state_t         state_q, state_d;
  logic [7:0]          row_q, row_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic [NUM_ROWS-1:0] mask_q, mask_d;
  logic [4:0]          count_q, count_d;
  logic [15:0]         lines_q, lines_d;
  logic                err_q, err_d;
  logic                row_full;
  logic                timeout;
  logic [4:0]          count_next;
  logic [16:0]         lines_sum;

  row_full_check u_full (
    .cells_i (read_reg),
    .full_o  (row_full)
  );

`ifdef SCAN_TIMEOUT_EN
  logic [9:0] wd_q, wd_d;

  // Counter is held at zero outside REQ, so it restarts on every REQ entry.
  always_comb wd_d = (state_q == REQ) ? wd_q + 10'd1 : 10'd0;
  assign timeout = (state_q == REQ) && !row_ready && (wd_q == 10'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= 10'd0;
    else          wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    full_d     = full_q;
    mask_d     = mask_q;
    count_d    = count_q;
    lines_d    = lines_q;
    err_d      = err_q;
    count_next = count_q + {4'd0, full_q};
    lines_sum  = {1'b0, lines_q} + {12'd0, count_next};

    unique case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        busy_d  = 1'b1;
      end
      CLR: begin
        mask_d  = '0;
        count_d = '0;
        err_d   = 1'b0;
        row_d   = 8'(NUM_ROWS - 1);
        state_d = REQ;
      end
      REQ: if (row_ready) begin
        full_d                       = row_full;
        mask_d[row_q[ROW_IDX_W-1:0]] = row_full;
        state_d                      = CHK;
      end else if (timeout) begin
        // Aborted scan keeps its partial mask/count but never scores.
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = FIN;
      end
      CHK: begin
        count_d = count_next;
        if (row_q == 8'd0) begin
          done_d  = 1'b1;
          lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          state_d = FIN;
        end else begin
          row_d   = row_q - 8'd1;
          state_d = REQ;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      mask_q  <= '0;
      count_q <= 5'd0;
      lines_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= full_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      lines_q <= lines_d;
      err_q   <= err_d;
    end
  end

  // Drops in the row_ready cycle so the engine never re-reads the row.
  assign row_ld      = (state_q == REQ) && !row_ready;
  assign row         = row_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign full_mask   = mask_q;
  assign full_count  = count_q;
  assign lines_total = lines_q;
  assign scan_err    = err_q;

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Directed bench for row_scan_ctrl; the bench plays the row-read engine from a playfield table.
module tb_row_scan_ctrl;
  import tetris_pkg::*;

  localparam cell_t OCC = 16'h005F;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 row_ready = 1'b0;
  cell_t [NUM_COLS-1:0] read_reg;
  logic                 row_ld;
  logic [7:0]           row;
  logic                 busy;
  logic                 done;
  logic [NUM_ROWS-1:0]  full_mask;
  logic [4:0]           full_count;
  logic [15:0]          lines_total;
  logic                 scan_err;

  cell_t [NUM_COLS-1:0] field [NUM_ROWS];
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_hs;

  row_scan_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .row_ready   (row_ready),
    .read_reg    (read_reg),
    .row_ld      (row_ld),
    .row         (row),
    .busy        (busy),
    .done        (done),
    .full_mask   (full_mask),
    .full_count  (full_count),
    .lines_total (lines_total),
    .scan_err    (scan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) n_done++;
  endtask

  task automatic chk_reset();
    chk("rst_row_ld", row_ld, 0);
    chk("rst_row", row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", full_mask, 0);
    chk("rst_count", full_count, 0);
    chk("rst_lines", lines_total, 0);
    chk("rst_err", scan_err, 0);
  endtask

  task automatic fill_empty();
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++) field[r][c] = BKGD_CLR;
  endtask

  task automatic fill_row(input int r, input cell_t v);
    for (int c = 0; c < NUM_COLS; c++) field[r][c] = v;
  endtask

  // Rows 19/18 full, every other row has at least one empty cell.
  task automatic fill_mixed();
    for (int r = 0; r < NUM_ROWS - 2; r++)
      for (int c = 0; c < NUM_COLS; c++) field[r][c] = ((r + c) % 3 == 0) ? BKGD_CLR : OCC;
    fill_row(NUM_ROWS - 1, OCC);
    fill_row(NUM_ROWS - 2, OCC);
  endtask

  task automatic run_scan(input int stop_row, input bit mid_start, input bit fin_start,
                          output int hs);
    int exp_row;
    int w;
    n_done  = 0;
    hs      = 0;
    exp_row = NUM_ROWS - 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_clr", busy, 1);
    while (exp_row >= 0) begin
      w = 0;
      while (row_ld !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      chk("row_ld_req", row_ld, 1);
      if (row_ld !== 1'b1) return;
      chk("row_idx", row, exp_row);
      if (exp_row == stop_row) return;
      read_reg  = field[exp_row];
      row_ready = 1'b1;
      start     = mid_start && (exp_row == 10);
      #1;
      chk("row_ld_drop", row_ld, 0);
      tick();
      row_ready = 1'b0;
      start     = 1'b0;
      hs++;
      exp_row--;
    end
    w = 0;
    while (n_done == 0 && w < 8) begin
      tick();
      w++;
    end
    chk("done_seen", n_done, 1);
    if (fin_start) start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_fin", busy, 0);
    repeat (3) tick();
    chk("done_once", n_done, 1);
    chk("idle_no_restart", busy, 0);
  endtask

  initial begin
    read_reg = '0;
    fill_empty();

    #12;
    chk_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_reset();

    // Reset while requesting row 15 of a scan that already found rows 19/18 full
    fill_mixed();
    run_scan(15, 1'b0, 1'b0, n_hs);
    chk("t1_hs", n_hs, 4);
    chk("t1_row_ld_hi", row_ld, 1);
    chk("t1_row15", row, 15);
    chk("t1_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_row_ld_async", row_ld, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_reset();
    repeat (2) tick();
    chk("t1_stay_idle", row_ld, 0);

    // Empty field
    fill_empty();
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t2_hs", n_hs, 20);
    chk("t2_mask", full_mask, 20'h00000);
    chk("t2_count", full_count, 0);
    chk("t2_lines", lines_total, 0);
    chk("t2_err", scan_err, 0);

    // Two bottom rows full, rest mixed
    fill_mixed();
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t3_hs", n_hs, 20);
    chk("t3_mask", full_mask, 20'hC0000);
    chk("t3_count", full_count, 2);
    chk("t3_lines", lines_total, 2);

    // Row 10 one cell short, then completed
    fill_empty();
    fill_row(10, OCC);
    field[10][9] = BKGD_CLR;
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t4a_bit10", full_mask[10], 0);
    chk("t4a_mask", full_mask, 20'h00000);
    chk("t4a_lines", lines_total, 2);
    field[10][9] = OCC;
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t4b_bit10", full_mask[10], 1);
    chk("t4b_mask", full_mask, 20'h00400);
    chk("t4b_count", full_count, 1);
    chk("t4b_lines", lines_total, 3);

    // Stray row_ready in IDLE, then start pulses mid-scan and in FIN
    n_done = 0;
    for (int c = 0; c < NUM_COLS; c++) read_reg[c] = OCC;
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_row_ld", row_ld, 0);
    chk("t5_idle_mask", full_mask, 20'h00400);
    chk("t5_idle_count", full_count, 1);
    chk("t5_idle_done", n_done, 0);
    fill_empty();
    run_scan(-1, 1'b1, 1'b1, n_hs);
    chk("t5_hs", n_hs, 20);
    chk("t5_mask", full_mask, 20'h00000);
    chk("t5_lines", lines_total, 3);

`ifdef SCAN_TIMEOUT_EN
    begin
      int w;
      fill_mixed();
      run_scan(5, 1'b0, 1'b0, n_hs);
      w = 0;
      while (n_done == 0 && w < 1100) begin
        tick();
        w++;
      end
      chk("wd_done", n_done, 1);
      chk("wd_cycles", w, 1023);
      chk("wd_err", scan_err, 1);
      chk("wd_mask", full_mask, 20'hC0000);
      chk("wd_count", full_count, 2);
      chk("wd_lines", lines_total, 3);
      tick();
      chk("wd_idle", busy, 0);
      chk("wd_row_ld", row_ld, 0);
    end
`endif

    // Saturation: preset the running total, then 4-row scans
    fill_empty();
    for (int r = 0; r < 4; r++) fill_row(r, OCC);
    force dut.lines_q = 16'hFFFA;
    #1;
    release dut.lines_q;
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t6a_mask", full_mask, 20'h0000F);
    chk("t6a_count", full_count, 4);
    chk("t6a_lines", lines_total, 16'hFFFE);
    chk("t6a_err", scan_err, 0);
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t6b_lines_sat", lines_total, 16'hFFFF);
    run_scan(-1, 1'b0, 1'b0, n_hs);
    chk("t6c_lines_hold", lines_total, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
